eth_rx_noc_out: RTL and testbench
=================================

# eth_rx_noc_out

Receive-side counterpart of the Ethernet TX NoC ingress: takes a parsed Ethernet frame, a header struct plus a payload beat stream, from the RX Ethernet formatter and serialises it onto noc0 toward a destination tile. Each frame goes out as three parts in order:
- a NoC header flit;
- a metadata flit carrying the Ethernet header, payload length and timestamp;
- one data flit per payload beat.

The block sits between the RX Ethernet formatter and the tile's noc0 router port.

## Interface
Parameters:
- SRC_X, 0, X coordinate of this tile, written into the header flit.
- SRC_Y, 0, Y coordinate of this tile, written into the header flit.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- eth_format_eth_rx_out_eth_hdr_val  in  1  frame header valid.
- eth_format_eth_rx_out_eth_hdr  in  eth_hdr  parsed Ethernet header.
- eth_format_eth_rx_out_payload_len  in  MTU_SIZE_W  payload bytes.
- eth_format_eth_rx_out_timestamp  in  tracker_stats_struct  arrival timestamp.
- eth_format_eth_rx_out_dst_x  in  XY_WIDTH  destination tile X.
- eth_format_eth_rx_out_dst_y  in  XY_WIDTH  destination tile Y.
- eth_rx_out_eth_format_eth_hdr_rdy  out  1  header accepted.
- eth_format_eth_rx_out_data_val  in  1  payload beat valid.
- eth_format_eth_rx_out_data  in  MAC_INTERFACE_W  payload beat.
- eth_format_eth_rx_out_data_last  in  1  final beat of the frame.
- eth_format_eth_rx_out_data_padbytes  in  MAC_PADBYTES_W  invalid bytes in the final beat.
- eth_rx_out_eth_format_data_rdy  out  1  beat accepted.
- eth_rx_out_noc0_vrtoc_val  out  1  flit valid.
- eth_rx_out_noc0_vrtoc_data  out  NOC_DATA_WIDTH  flit.
- noc0_vrtoc_eth_rx_out_rdy  in  1  router ready.
- eth_rx_out_proto_err  out  1  one-cycle pulse on data_last / flit-count mismatch.
- eth_rd_log  out  1  one-cycle pulse on handshake of the frame's final flit.
- eth_rd_log_start_timestamp  out  tracker_stats_struct  timestamp of the frame in flight.

## Operation
- Requirement: MAC_INTERFACE_W == NOC_DATA_WIDTH; one payload beat maps to one data flit. BYTES_PER_FLIT = NOC_DATA_WIDTH/8.
- Data flit count: data_flits = (payload_len + BYTES_PER_FLIT-1) >> log2(BYTES_PER_FLIT).
  - Computed in MTU_SIZE_W+1 bits, so no overflow at the maximum MTU.
- Header flit fields:
  - dst_x and dst_y as latched from the inputs;
  - src_x = SRC_X, src_y = SRC_Y;
  - msg_type = ETH_RX_MSG;
  - msg_len = 1 + data_flits; counts flits after the header flit.
- Meta flit: eth_hdr, payload_len and timestamp, left-aligned, zero-filled.
- State machine:
  - IDLE: hdr_rdy = 1. On hdr_val, latch header, length, timestamp and destination, load the counter with data_flits, go to HDR.
  - HDR: noc val = 1 carrying the header flit. On noc handshake go to META.
  - META: noc val = 1 carrying the meta flit. On handshake, go to DATA if data_flits != 0, else to IDLE and pulse eth_rd_log.
  - DATA: combinational pass-through. noc val = data_val, data_rdy = noc rdy, noc data = payload beat.
    - Each handshake decrements the counter.
    - On the handshake where the counter is 1: pulse eth_rd_log, go to IDLE.
- Protocol error: in DATA, pulse proto_err when either
  - data_last = 1 with counter != 1, or
  - data_last = 0 with counter == 1.
  - The counter alone still terminates the frame; the NoC message length is never violated.
- Ports hdr_rdy and data_rdy are 0 in every state other than their own; no overlap between frames.

## Timing
- Reset values: state = IDLE, counter = 0, latched registers = 0.
  - Outputs after reset: noc val = 0, hdr_rdy = 1, data_rdy = 0, proto_err = 0, eth_rd_log = 0.
- Latency: the header flit is valid the cycle after the eth header handshake. The meta flit follows one cycle after the header flit handshake at the earliest.
- Throughput: in DATA, one flit per cycle under back-to-back valid/ready.
  - Frame-to-frame minimum overhead is 3 cycles: IDLE + HDR + META.
- noc val and flit data stay stable while rdy = 0 in HDR and META. In DATA they mirror upstream, which must itself hold.
- A reset assertion mid-frame returns asynchronously to IDLE. The partial NoC message is abandoned.
- payload_len = 0 gives msg_len = 1: header + meta only.

## Structure
- Package eth_rx_noc_out_pkg (or the existing NoC/eth packages) holds:
  - the state enum;
  - the meta flit struct;
  - ETH_RX_MSG;
  - BYTES_PER_FLIT.
- The header flit struct comes from the shared NoC package.
- Natural split: eth_rx_noc_out_ctrl (FSM, counter, handshakes, log/err pulses) and eth_rx_noc_out_datap (latches, length arithmetic, flit mux).

## Test plan
- payload_len = 128, two beats, rdy always 1, dst (2,3) → header flit msg_len = 3, dst (2,3), src (SRC_X,SRC_Y); meta flit then 2 data flits on consecutive cycles; eth_rd_log pulses once, on the 2nd data flit.
- payload_len = 65 → msg_len = 3, 2 data flits; payload_len = 64 → msg_len = 2.
- payload_len = 0 → header + meta only, msg_len = 1; eth_rd_log pulses on the meta flit; return to IDLE.
- noc rdy random 50% throughout a 1500-byte frame → flits held stable while stalled; 24 data flits delivered in order; no beat lost or duplicated.
- 3-beat frame with data_last on beat 2 → proto_err pulse on beat 2; third beat still forwarded; eth_rd_log on beat 3.
- rst asserted low during DATA → outputs return to reset values immediately; the next frame emits a correct header flit.

Source files
------------

// File: rtl/eth_rx_noc_out_pkg.sv
// Shared types and constants for the RX Ethernet-to-noc0 serialiser.
// Holds the flit layouts, the FSM state encoding and the flit-count helper.
package eth_rx_noc_out_pkg;
  localparam int NOC_DATA_WIDTH  = 512;
  localparam int MAC_INTERFACE_W = NOC_DATA_WIDTH;
  localparam int MAC_PADBYTES_W  = 6;
  localparam int MTU_SIZE_W      = 16;
  localparam int XY_WIDTH        = 8;
  localparam int MSG_LEN_W       = 16;
  localparam int MSG_TYPE_W      = 8;
  localparam int BYTES_PER_FLIT  = NOC_DATA_WIDTH / 8;
  localparam int FLIT_SHIFT      = $clog2(BYTES_PER_FLIT);
  localparam int CNT_W           = MTU_SIZE_W + 1 - FLIT_SHIFT;

  localparam logic [MSG_TYPE_W-1:0] ETH_RX_MSG = 8'h0B;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_META, ST_DATA} state_e;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } eth_hdr;

  typedef struct packed {
    logic [63:0] timestamp;
  } tracker_stats_struct;

  typedef struct packed {
    logic [XY_WIDTH-1:0]   dst_x;
    logic [XY_WIDTH-1:0]   dst_y;
    logic [XY_WIDTH-1:0]   src_x;
    logic [XY_WIDTH-1:0]   src_y;
    logic [MSG_LEN_W-1:0]  msg_len;
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [NOC_DATA_WIDTH-4*XY_WIDTH-MSG_LEN_W-MSG_TYPE_W-1:0] rsvd;
  } noc_hdr_flit_t;

  typedef struct packed {
    eth_hdr                  hdr;
    logic [MTU_SIZE_W-1:0]   payload_len;
    tracker_stats_struct     timestamp;
    logic [NOC_DATA_WIDTH-$bits(eth_hdr)-MTU_SIZE_W-$bits(tracker_stats_struct)-1:0] rsvd;
  } noc_meta_flit_t;

  // One extra bit on the sum so a maximum-length payload cannot wrap.
  function automatic logic [CNT_W-1:0] calc_data_flits(input logic [MTU_SIZE_W-1:0] len);
    logic [MTU_SIZE_W:0] w_sum;
    w_sum = {1'b0, len} + (MTU_SIZE_W+1)'(BYTES_PER_FLIT - 1);
    return CNT_W'(w_sum >> FLIT_SHIFT);
  endfunction
endpackage

// File: rtl/eth_rx_noc_out_if.sv
// Formatter-side and noc0-side handshake bundle of the RX serialiser.
// slave = the serialiser itself, master = formatter plus router.
interface eth_rx_noc_out_if;
  import eth_rx_noc_out_pkg::*;
  logic                       eth_format_eth_rx_out_eth_hdr_val;
  eth_hdr                     eth_format_eth_rx_out_eth_hdr;
  logic [MTU_SIZE_W-1:0]      eth_format_eth_rx_out_payload_len;
  tracker_stats_struct        eth_format_eth_rx_out_timestamp;
  logic [XY_WIDTH-1:0]        eth_format_eth_rx_out_dst_x;
  logic [XY_WIDTH-1:0]        eth_format_eth_rx_out_dst_y;
  logic                       eth_rx_out_eth_format_eth_hdr_rdy;
  logic                       eth_format_eth_rx_out_data_val;
  logic [MAC_INTERFACE_W-1:0] eth_format_eth_rx_out_data;
  logic                       eth_format_eth_rx_out_data_last;
  logic [MAC_PADBYTES_W-1:0]  eth_format_eth_rx_out_data_padbytes;
  logic                       eth_rx_out_eth_format_data_rdy;
  logic                       eth_rx_out_noc0_vrtoc_val;
  logic [NOC_DATA_WIDTH-1:0]  eth_rx_out_noc0_vrtoc_data;
  logic                       noc0_vrtoc_eth_rx_out_rdy;
  logic                       eth_rx_out_proto_err;
  logic                       eth_rd_log;
  tracker_stats_struct        eth_rd_log_start_timestamp;

  modport slave (
    input  eth_format_eth_rx_out_eth_hdr_val, eth_format_eth_rx_out_eth_hdr,
           eth_format_eth_rx_out_payload_len, eth_format_eth_rx_out_timestamp,
           eth_format_eth_rx_out_dst_x, eth_format_eth_rx_out_dst_y,
           eth_format_eth_rx_out_data_val, eth_format_eth_rx_out_data,
           eth_format_eth_rx_out_data_last, eth_format_eth_rx_out_data_padbytes,
           noc0_vrtoc_eth_rx_out_rdy,
    output eth_rx_out_eth_format_eth_hdr_rdy, eth_rx_out_eth_format_data_rdy,
           eth_rx_out_noc0_vrtoc_val, eth_rx_out_noc0_vrtoc_data,
           eth_rx_out_proto_err, eth_rd_log, eth_rd_log_start_timestamp
  );

  modport master (
    output eth_format_eth_rx_out_eth_hdr_val, eth_format_eth_rx_out_eth_hdr,
           eth_format_eth_rx_out_payload_len, eth_format_eth_rx_out_timestamp,
           eth_format_eth_rx_out_dst_x, eth_format_eth_rx_out_dst_y,
           eth_format_eth_rx_out_data_val, eth_format_eth_rx_out_data,
           eth_format_eth_rx_out_data_last, eth_format_eth_rx_out_data_padbytes,
           noc0_vrtoc_eth_rx_out_rdy,
    input  eth_rx_out_eth_format_eth_hdr_rdy, eth_rx_out_eth_format_data_rdy,
           eth_rx_out_noc0_vrtoc_val, eth_rx_out_noc0_vrtoc_data,
           eth_rx_out_proto_err, eth_rd_log, eth_rd_log_start_timestamp
  );
endinterface

// File: rtl/eth_rx_noc_out_ctrl.sv
// Frame sequencing FSM: flit-count tracking, handshakes, log and error pulses.
// Latency: Mealy outputs, 0 cycles; backpressure: holds in HDR/META, passes rdy through in DATA.
module eth_rx_noc_out_ctrl
  import eth_rx_noc_out_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hdr_val,
  input  logic             i_data_val,
  input  logic             i_data_last,
  input  logic             i_noc_rdy,
  input  logic [CNT_W-1:0] i_data_flits,
  output state_e           o_state,
  output logic             o_hdr_hs,
  output logic             o_hdr_rdy,
  output logic             o_data_rdy,
  output logic             o_noc_val,
  output logic             o_rd_log,
  output logic             o_proto_err
);
  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_data_hs;
  logic             w_cnt_one;

  assign w_data_hs = (r_state == ST_DATA) && i_data_val && i_noc_rdy;
  assign w_cnt_one = (r_cnt == CNT_W'(1));
  assign o_state   = r_state;
  assign o_hdr_hs  = (r_state == ST_IDLE) && i_hdr_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (o_hdr_hs)
        r_cnt <= i_data_flits;
      else if (w_data_hs)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_hdr_val) w_next = ST_HDR;
      ST_HDR:  if (i_noc_rdy) w_next = ST_META;
      ST_META: if (i_noc_rdy) w_next = (r_cnt != '0) ? ST_DATA : ST_IDLE;
      ST_DATA: if (w_data_hs && w_cnt_one) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The counter, not data_last, ends the frame so msg_len is always honoured.
  always_comb begin
    o_hdr_rdy   = (r_state == ST_IDLE);
    o_data_rdy  = (r_state == ST_DATA) && i_noc_rdy;
    o_noc_val   = (r_state == ST_HDR) || (r_state == ST_META) ||
                  ((r_state == ST_DATA) && i_data_val);
    o_rd_log    = ((r_state == ST_META) && i_noc_rdy && (r_cnt == '0)) ||
                  (w_data_hs && w_cnt_one);
    o_proto_err = w_data_hs && (i_data_last != w_cnt_one);
  end
endmodule

// File: rtl/eth_rx_noc_out_datap.sv
// Frame descriptor latches, flit-count arithmetic and the noc0 flit mux.
// Latency: descriptor captured on header handshake; flit mux is combinational.
module eth_rx_noc_out_datap
  import eth_rx_noc_out_pkg::*;
#(
  parameter int SRC_X = 0,
  parameter int SRC_Y = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_hdr_hs,
  input  state_e                     i_state,
  input  eth_hdr                     i_eth_hdr,
  input  logic [MTU_SIZE_W-1:0]      i_payload_len,
  input  tracker_stats_struct        i_timestamp,
  input  logic [XY_WIDTH-1:0]        i_dst_x,
  input  logic [XY_WIDTH-1:0]        i_dst_y,
  input  logic [MAC_INTERFACE_W-1:0] i_data,
  output logic [CNT_W-1:0]           o_data_flits,
  output logic [NOC_DATA_WIDTH-1:0]  o_noc_data,
  output tracker_stats_struct        o_timestamp
);
  eth_hdr                r_eth_hdr;
  logic [MTU_SIZE_W-1:0] r_payload_len;
  tracker_stats_struct   r_timestamp;
  logic [XY_WIDTH-1:0]   r_dst_x;
  logic [XY_WIDTH-1:0]   r_dst_y;
  noc_hdr_flit_t         w_hdr_flit;
  noc_meta_flit_t        w_meta_flit;

  assign o_data_flits = calc_data_flits(i_payload_len);
  assign o_timestamp  = r_timestamp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_eth_hdr     <= '0;
      r_payload_len <= '0;
      r_timestamp   <= '0;
      r_dst_x       <= '0;
      r_dst_y       <= '0;
    end else if (i_hdr_hs) begin
      r_eth_hdr     <= i_eth_hdr;
      r_payload_len <= i_payload_len;
      r_timestamp   <= i_timestamp;
      r_dst_x       <= i_dst_x;
      r_dst_y       <= i_dst_y;
    end
  end

  // msg_len counts the meta flit plus every data flit.
  always_comb begin
    w_hdr_flit          = '0;
    w_hdr_flit.dst_x    = r_dst_x;
    w_hdr_flit.dst_y    = r_dst_y;
    w_hdr_flit.src_x    = XY_WIDTH'(SRC_X);
    w_hdr_flit.src_y    = XY_WIDTH'(SRC_Y);
    w_hdr_flit.msg_len  = MSG_LEN_W'(calc_data_flits(r_payload_len)) + MSG_LEN_W'(1);
    w_hdr_flit.msg_type = ETH_RX_MSG;
    w_meta_flit             = '0;
    w_meta_flit.hdr         = r_eth_hdr;
    w_meta_flit.payload_len = r_payload_len;
    w_meta_flit.timestamp   = r_timestamp;
  end

  always_comb begin
    o_noc_data = '0;
    case (i_state)
      ST_HDR:  o_noc_data = w_hdr_flit;
      ST_META: o_noc_data = w_meta_flit;
      ST_DATA: o_noc_data = i_data;
      default: o_noc_data = '0;
    endcase
  end
endmodule

// File: rtl/eth_rx_noc_out.sv
// Serialises a parsed RX Ethernet frame onto noc0 as header, meta and data flits.
// Latency: header flit valid 1 cycle after hdr handshake; data beats pass straight through.
// Backpressure: router rdy stalls HDR/META in place and is forwarded upstream as data_rdy.
module eth_rx_noc_out
  import eth_rx_noc_out_pkg::*;
#(
  parameter int SRC_X = 0,
  parameter int SRC_Y = 0
) (
  input  logic               clk,
  input  logic               rst,
  eth_rx_noc_out_if.slave    io
);
  state_e           w_state;
  logic             w_hdr_hs;
  logic [CNT_W-1:0] w_data_flits;
  logic             w_unused_padbytes;

  assign w_unused_padbytes = ^io.eth_format_eth_rx_out_data_padbytes;

  eth_rx_noc_out_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .i_hdr_val    (io.eth_format_eth_rx_out_eth_hdr_val),
    .i_data_val   (io.eth_format_eth_rx_out_data_val),
    .i_data_last  (io.eth_format_eth_rx_out_data_last),
    .i_noc_rdy    (io.noc0_vrtoc_eth_rx_out_rdy),
    .i_data_flits (w_data_flits),
    .o_state      (w_state),
    .o_hdr_hs     (w_hdr_hs),
    .o_hdr_rdy    (io.eth_rx_out_eth_format_eth_hdr_rdy),
    .o_data_rdy   (io.eth_rx_out_eth_format_data_rdy),
    .o_noc_val    (io.eth_rx_out_noc0_vrtoc_val),
    .o_rd_log     (io.eth_rd_log),
    .o_proto_err  (io.eth_rx_out_proto_err)
  );

  eth_rx_noc_out_datap #(.SRC_X(SRC_X), .SRC_Y(SRC_Y)) u_datap (
    .clk           (clk),
    .rst           (rst),
    .i_hdr_hs      (w_hdr_hs),
    .i_state       (w_state),
    .i_eth_hdr     (io.eth_format_eth_rx_out_eth_hdr),
    .i_payload_len (io.eth_format_eth_rx_out_payload_len),
    .i_timestamp   (io.eth_format_eth_rx_out_timestamp),
    .i_dst_x       (io.eth_format_eth_rx_out_dst_x),
    .i_dst_y       (io.eth_format_eth_rx_out_dst_y),
    .i_data        (io.eth_format_eth_rx_out_data),
    .o_data_flits  (w_data_flits),
    .o_noc_data    (io.eth_rx_out_noc0_vrtoc_data),
    .o_timestamp   (io.eth_rd_log_start_timestamp)
  );
endmodule

// File: tb/tb_eth_rx_noc_out.sv
// Directed bench for eth_rx_noc_out: drives and samples on the falling edge.
module tb_eth_rx_noc_out;
  import eth_rx_noc_out_pkg::*;
  localparam int SX = 5;
  localparam int SY = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eth_rx_noc_out_if u_if ();
  eth_rx_noc_out #(.SRC_X(SX), .SRC_Y(SY)) u_dut (.clk(clk), .rst(rst), .io(u_if.slave));

  int n_pass  = 0;
  int n_total = 0;

  logic         hrdy, nv, drdy, lg, er;
  logic [511:0] nd;

  function automatic logic [511:0] beat(input int f, input int i);
    return {8{32'(f), 32'(i)}};
  endfunction

  function automatic eth_hdr mk_ehdr(input int f);
    eth_hdr e;
    e.dst_mac  = 48'h0200_0000_0000 + 48'(f);
    e.src_mac  = 48'h0400_0000_0000 + 48'(f);
    e.eth_type = 16'h0800;
    return e;
  endfunction

  function automatic tracker_stats_struct mk_ts(input int f);
    tracker_stats_struct t;
    t.timestamp = 64'h0000_1000_0000_0000 + 64'(f);
    return t;
  endfunction

  function automatic logic [511:0] mk_hdr(input logic [7:0] dx, input logic [7:0] dy, input logic [15:0] ml);
    noc_hdr_flit_t h;
    h = '0;
    h.dst_x = dx; h.dst_y = dy; h.src_x = 8'(SX); h.src_y = 8'(SY);
    h.msg_len = ml; h.msg_type = 8'h0B;
    return h;
  endfunction

  function automatic logic [511:0] mk_meta(input int f, input logic [15:0] len);
    noc_meta_flit_t m;
    m = '0;
    m.hdr = mk_ehdr(f); m.payload_len = len; m.timestamp = mk_ts(f);
    return m;
  endfunction

  task automatic start_frame(input int f, input logic [15:0] len, input logic [7:0] dx,
                             input logic [7:0] dy, output logic o_hrdy, output logic o_nv);
    @(negedge clk);
    u_if.eth_format_eth_rx_out_eth_hdr_val = 1'b1;
    u_if.eth_format_eth_rx_out_eth_hdr     = mk_ehdr(f);
    u_if.eth_format_eth_rx_out_payload_len = len;
    u_if.eth_format_eth_rx_out_timestamp   = mk_ts(f);
    u_if.eth_format_eth_rx_out_dst_x       = dx;
    u_if.eth_format_eth_rx_out_dst_y       = dy;
    u_if.eth_format_eth_rx_out_data_val    = 1'b0;
    #1;
    o_hrdy = u_if.eth_rx_out_eth_format_eth_hdr_rdy;
    o_nv   = u_if.eth_rx_out_noc0_vrtoc_val;
  endtask

  task automatic cycle_flit(input logic rdy, input logic dv, input logic [511:0] d, input logic last,
                            output logic o_nv, output logic [511:0] o_nd, output logic o_drdy,
                            output logic o_log, output logic o_err);
    @(negedge clk);
    u_if.eth_format_eth_rx_out_eth_hdr_val = 1'b0;
    u_if.noc0_vrtoc_eth_rx_out_rdy         = rdy;
    u_if.eth_format_eth_rx_out_data_val    = dv;
    u_if.eth_format_eth_rx_out_data        = d;
    u_if.eth_format_eth_rx_out_data_last   = last;
    #1;
    o_nv   = u_if.eth_rx_out_noc0_vrtoc_val;
    o_nd   = u_if.eth_rx_out_noc0_vrtoc_data;
    o_drdy = u_if.eth_rx_out_eth_format_data_rdy;
    o_log  = u_if.eth_rd_log;
    o_err  = u_if.eth_rx_out_proto_err;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (u_if.eth_rx_out_noc0_vrtoc_val !== 1'b0) $display("FAIL rst_noc_val got %b exp 0", u_if.eth_rx_out_noc0_vrtoc_val); else n_pass++;
    n_total++; if (u_if.eth_rx_out_eth_format_eth_hdr_rdy !== 1'b1) $display("FAIL rst_hdr_rdy got %b exp 1", u_if.eth_rx_out_eth_format_eth_hdr_rdy); else n_pass++;
    n_total++; if (u_if.eth_rx_out_eth_format_data_rdy !== 1'b0) $display("FAIL rst_data_rdy got %b exp 0", u_if.eth_rx_out_eth_format_data_rdy); else n_pass++;
    n_total++; if (u_if.eth_rx_out_proto_err !== 1'b0 || u_if.eth_rd_log !== 1'b0) $display("FAIL rst_pulses got err=%b log=%b exp 0/0", u_if.eth_rx_out_proto_err, u_if.eth_rd_log); else n_pass++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic();
    start_frame(1, 16'd128, 8'd2, 8'd3, hrdy, nv);
    n_total++; if (hrdy !== 1'b1 || nv !== 1'b0) $display("FAIL basic_idle got hrdy=%b val=%b exp 1/0", hrdy, nv); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nv !== 1'b1 || nd !== mk_hdr(8'd2, 8'd3, 16'd3)) $display("FAIL basic_hdr got %h exp %h", nd, mk_hdr(8'd2, 8'd3, 16'd3)); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nv !== 1'b1 || nd !== mk_meta(1, 16'd128) || lg !== 1'b0) $display("FAIL basic_meta got %h log=%b", nd, lg); else n_pass++;
    cycle_flit(1'b1, 1'b1, beat(1, 0), 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nv !== 1'b1 || drdy !== 1'b1 || nd !== beat(1, 0) || lg !== 1'b0) $display("FAIL basic_d0 got val=%b rdy=%b log=%b", nv, drdy, lg); else n_pass++;
    n_total++; if (u_if.eth_rd_log_start_timestamp !== mk_ts(1)) $display("FAIL basic_ts got %h exp %h", u_if.eth_rd_log_start_timestamp, mk_ts(1)); else n_pass++;
    cycle_flit(1'b1, 1'b1, beat(1, 1), 1'b1, nv, nd, drdy, lg, er);
    n_total++; if (nd !== beat(1, 1) || lg !== 1'b1 || er !== 1'b0) $display("FAIL basic_d1 got log=%b err=%b", lg, er); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nv !== 1'b0 || lg !== 1'b0 || u_if.eth_rx_out_eth_format_eth_hdr_rdy !== 1'b1) $display("FAIL basic_end got val=%b log=%b", nv, lg); else n_pass++;
  endtask

  task automatic test_lengths();
    start_frame(2, 16'd65, 8'd1, 8'd1, hrdy, nv);
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nd !== mk_hdr(8'd1, 8'd1, 16'd3)) $display("FAIL len65_hdr got %h", nd); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    cycle_flit(1'b1, 1'b1, beat(2, 0), 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (lg !== 1'b0) $display("FAIL len65_d0_log got %b exp 0", lg); else n_pass++;
    cycle_flit(1'b1, 1'b1, beat(2, 1), 1'b1, nv, nd, drdy, lg, er);
    n_total++; if (lg !== 1'b1 || nd !== beat(2, 1)) $display("FAIL len65_d1 got log=%b", lg); else n_pass++;
    start_frame(3, 16'd64, 8'd1, 8'd2, hrdy, nv);
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nd !== mk_hdr(8'd1, 8'd2, 16'd2)) $display("FAIL len64_hdr got %h", nd); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    cycle_flit(1'b1, 1'b1, beat(3, 0), 1'b1, nv, nd, drdy, lg, er);
    n_total++; if (lg !== 1'b1 || er !== 1'b0 || nd !== beat(3, 0)) $display("FAIL len64_d0 got log=%b err=%b", lg, er); else n_pass++;
  endtask

  task automatic test_zero_len();
    start_frame(4, 16'd0, 8'd6, 8'd6, hrdy, nv);
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nd !== mk_hdr(8'd6, 8'd6, 16'd1) || lg !== 1'b0) $display("FAIL zero_hdr got %h log=%b", nd, lg); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nd !== mk_meta(4, 16'd0) || lg !== 1'b1) $display("FAIL zero_meta got log=%b", lg); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nv !== 1'b0 || u_if.eth_rx_out_eth_format_eth_hdr_rdy !== 1'b1) $display("FAIL zero_idle got val=%b", nv); else n_pass++;
  endtask

  task automatic test_stall();
    logic [511:0] exp_q [26];
    int idx = 0, cyc = 0, logs = 0;
    logic r, dv;
    exp_q[0] = mk_hdr(8'd3, 8'd0, 16'd25);
    exp_q[1] = mk_meta(5, 16'd1500);
    for (int i = 0; i < 24; i++) exp_q[i+2] = beat(5, i);
    start_frame(5, 16'd1500, 8'd3, 8'd0, hrdy, nv);
    while (idx < 26 && cyc < 400) begin
      r  = 1'($urandom_range(0, 1));
      dv = (idx >= 2);
      cycle_flit(r, dv, dv ? exp_q[idx] : '0, (idx == 25), nv, nd, drdy, lg, er);
      n_total++; if (nv !== 1'b1 || nd !== exp_q[idx]) $display("FAIL stall_flit%0d got val=%b data=%h", idx, nv, nd); else n_pass++;
      if (dv) begin
        n_total++; if (drdy !== r) $display("FAIL stall_drdy%0d got %b exp %b", idx, drdy, r); else n_pass++;
      end
      n_total++; if (lg !== (r && idx == 25)) $display("FAIL stall_log%0d got %b exp %b", idx, lg, r && idx == 25); else n_pass++;
      if (lg) logs++;
      if (r) idx++;
      cyc++;
    end
    n_total++; if (idx != 26) $display("FAIL stall_timeout got %0d flits exp 26", idx); else n_pass++;
    n_total++; if (logs != 1) $display("FAIL stall_logcount got %0d exp 1", logs); else n_pass++;
  endtask

  task automatic test_proto_err();
    start_frame(6, 16'd192, 8'd2, 8'd2, hrdy, nv);
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nd !== mk_hdr(8'd2, 8'd2, 16'd4)) $display("FAIL perr_hdr got %h", nd); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    cycle_flit(1'b1, 1'b1, beat(6, 0), 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (er !== 1'b0) $display("FAIL perr_b0 got err=%b exp 0", er); else n_pass++;
    cycle_flit(1'b1, 1'b1, beat(6, 1), 1'b1, nv, nd, drdy, lg, er);
    n_total++; if (er !== 1'b1 || lg !== 1'b0) $display("FAIL perr_b1 got err=%b log=%b exp 1/0", er, lg); else n_pass++;
    cycle_flit(1'b1, 1'b1, beat(6, 2), 1'b1, nv, nd, drdy, lg, er);
    n_total++; if (er !== 1'b0 || lg !== 1'b1 || nv !== 1'b1 || nd !== beat(6, 2)) $display("FAIL perr_b2 got err=%b log=%b val=%b", er, lg, nv); else n_pass++;
  endtask

  task automatic test_reset_mid();
    start_frame(7, 16'd128, 8'd2, 8'd3, hrdy, nv);
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    cycle_flit(1'b1, 1'b1, beat(7, 0), 1'b0, nv, nd, drdy, lg, er);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (u_if.eth_rx_out_noc0_vrtoc_val !== 1'b0 || u_if.eth_rx_out_eth_format_data_rdy !== 1'b0) $display("FAIL mid_rst_val got val=%b drdy=%b exp 0/0", u_if.eth_rx_out_noc0_vrtoc_val, u_if.eth_rx_out_eth_format_data_rdy); else n_pass++;
    n_total++; if (u_if.eth_rx_out_eth_format_eth_hdr_rdy !== 1'b1 || u_if.eth_rd_log !== 1'b0) $display("FAIL mid_rst_rdy got hrdy=%b log=%b exp 1/0", u_if.eth_rx_out_eth_format_eth_hdr_rdy, u_if.eth_rd_log); else n_pass++;
    @(negedge clk);
    u_if.eth_format_eth_rx_out_data_val = 1'b0;
    rst = 1'b1;
    start_frame(8, 16'd64, 8'd4, 8'd1, hrdy, nv);
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nv !== 1'b1 || nd !== mk_hdr(8'd4, 8'd1, 16'd2)) $display("FAIL mid_next_hdr got %h", nd); else n_pass++;
    cycle_flit(1'b1, 1'b0, '0, 1'b0, nv, nd, drdy, lg, er);
    n_total++; if (nd !== mk_meta(8, 16'd64)) $display("FAIL mid_next_meta got %h", nd); else n_pass++;
    cycle_flit(1'b1, 1'b1, beat(8, 0), 1'b1, nv, nd, drdy, lg, er);
    n_total++; if (lg !== 1'b1 || nd !== beat(8, 0)) $display("FAIL mid_next_d0 got log=%b", lg); else n_pass++;
  endtask

  initial begin
    u_if.eth_format_eth_rx_out_eth_hdr_val   = 1'b0;
    u_if.eth_format_eth_rx_out_eth_hdr       = '0;
    u_if.eth_format_eth_rx_out_payload_len   = '0;
    u_if.eth_format_eth_rx_out_timestamp     = '0;
    u_if.eth_format_eth_rx_out_dst_x         = '0;
    u_if.eth_format_eth_rx_out_dst_y         = '0;
    u_if.eth_format_eth_rx_out_data_val      = 1'b0;
    u_if.eth_format_eth_rx_out_data          = '0;
    u_if.eth_format_eth_rx_out_data_last     = 1'b0;
    u_if.eth_format_eth_rx_out_data_padbytes = '0;
    u_if.noc0_vrtoc_eth_rx_out_rdy           = 1'b0;
    test_reset();
    test_basic();
    test_lengths();
    test_zero_len();
    test_stall();
    test_proto_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
